// File: rtl/m_alu_exec_unit.sv
// m_alu_exec_unit: EX-stage ALU with an iterative shift-add multiplier / restoring divider
// behind a valid/ready handshake on both sides.
module m_alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dbz,
    output logic             ill_op
);
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MUL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc_hi, acc_lo, op_b, cnt;
    logic             signed_mul, neg;
    logic             rtype, is_add, is_sub, is_and, is_or, is_slt, is_mul, is_multu, is_divu, is_ill;
    logic             accept, start_mul, start_div, div0, last, ld, sc_ovf;
    logic [WIDTH-1:0] sum_ab, dif_ab, sc_res, a_mag, b_mag;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, mul_res, div_hi_nx, div_lo_nx, ld_res, ld_hi;
    logic [WIDTH:0]   mul_sum, div_t;

    assign rtype    = aluop == 2'b10;
    assign is_add   = aluop == 2'b00 || (rtype && funct == F_ADD);
    assign is_sub   = aluop == 2'b01 || (rtype && funct == F_SUB);
    assign is_and   = rtype && funct == F_AND;
    assign is_or    = rtype && funct == F_OR;
    assign is_slt   = rtype && funct == F_SLT;
    assign is_mul   = rtype && funct == F_MUL;
    assign is_multu = rtype && funct == F_MULTU;
    assign is_divu  = rtype && funct == F_DIVU;
    assign is_ill   = !(is_add || is_sub || is_and || is_or || is_slt || is_mul || is_multu || is_divu);

    assign in_ready  = state == IDLE && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign div0      = is_divu && src_b == '0;
    assign start_mul = accept && (is_mul || is_multu);
    assign start_div = accept && is_divu && !div0;
    assign last      = cnt == WIDTH'(WIDTH - 1);

    assign sum_ab = src_a + src_b;
    assign dif_ab = src_a - src_b;
    assign a_mag  = src_a[WIDTH-1] ? -src_a : src_a;
    assign b_mag  = src_b[WIDTH-1] ? -src_b : src_b;
    assign sc_res = is_add ? sum_ab :
                    is_sub ? dif_ab :
                    is_and ? (src_a & src_b) :
                    is_or  ? (src_a | src_b) :
                    is_slt ? {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)} : '0;
    assign sc_ovf = is_add ? (src_a[WIDTH-1] == src_b[WIDTH-1] && sum_ab[WIDTH-1] != src_a[WIDTH-1]) :
                    is_sub ? (src_a[WIDTH-1] != src_b[WIDTH-1] && dif_ab[WIDTH-1] != src_a[WIDTH-1]) : 1'b0;

    // {acc_hi,acc_lo} holds partial product over multiplier; shifts right one bit per step
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, op_b & {WIDTH{acc_lo[0]}}};
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    assign mul_res   = neg ? -mul_lo_nx : mul_lo_nx;

    // acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in
    assign div_t     = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_b};
    assign div_hi_nx = div_t[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : div_t[WIDTH-1:0];
    assign div_lo_nx = {acc_lo[WIDTH-2:0], !div_t[WIDTH]};

    assign ld     = state == IDLE ? accept && !start_mul && !start_div : last;
    assign ld_res = state == MUL ? mul_res : state == DIV ? div_lo_nx : div0 ? '1 : sc_res;
    assign ld_hi  = state == MUL ? (signed_mul ? '0 : mul_hi_nx) : state == DIV ? div_hi_nx : div0 ? src_a : '0;

    always_comb begin
        state_nx = flush ? IDLE : start_mul ? MUL : start_div ? DIV : (state != IDLE && last) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            hi         <= '0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
            dbz        <= 1'b0;
            ill_op     <= 1'b0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            op_b       <= '0;
            cnt        <= '0;
            signed_mul <= 1'b0;
            neg        <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (ld) begin
                out_valid <= 1'b1;
                result    <= ld_res;
                hi        <= ld_hi;
                zero      <= ld_res == '0;
                ovf       <= state == IDLE && sc_ovf;
                dbz       <= state == IDLE && div0;
                ill_op    <= state == IDLE && is_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (start_mul || start_div) begin
                acc_hi     <= '0;
                acc_lo     <= is_mul ? a_mag : src_a;
                op_b       <= is_mul ? b_mag : src_b;
                cnt        <= '0;
                signed_mul <= is_mul;
                neg        <= is_mul && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            end else if (state != IDLE) begin
                acc_hi <= state == MUL ? mul_hi_nx : div_hi_nx;
                acc_lo <= state == MUL ? mul_lo_nx : div_lo_nx;
                cnt    <= cnt + WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_m_alu_exec_unit.sv
// tb_m_alu_exec_unit: scoreboard bench; expected responses come from an arithmetic
// reference model and are matched by a monitor whenever the DUT hands off a result.
module tb_m_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0]   aluop = '0;
    logic [5:0]   funct = '0;
    logic [W-1:0] src_a = '0, src_b = '0;
    logic         in_ready, out_valid, zero, ovf, dbz, ill_op;
    logic [W-1:0] result, hi;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero, ovf, dbz, ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e, mon_g;
    int   checks = 0, errors = 0;
    bit   rdy_rand = 1'b0, rdy_force = 1'b1;
    logic [5:0] functs [8] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                               6'b101010, 6'b000010, 6'b011001, 6'b011011};

    always #5 clk = ~clk;

    m_alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi),
        .zero(zero), .ovf(ovf), .dbz(dbz), .ill_op(ill_op)
    );

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sbv, s;
        logic [63:0] p;
        e   = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (op == 2'b00 || (op == 2'b10 && f == 6'b100000)) begin
            s = sa + sbv;
            e.res = a + b;
            e.ovf = s > 64'sd2147483647 || s < -64'sd2147483648;
        end else if (op == 2'b01 || (op == 2'b10 && f == 6'b100010)) begin
            s = sa - sbv;
            e.res = a - b;
            e.ovf = s > 64'sd2147483647 || s < -64'sd2147483648;
        end else if (op == 2'b10 && f == 6'b100100) e.res = a & b;
        else if (op == 2'b10 && f == 6'b100101) e.res = a | b;
        else if (op == 2'b10 && f == 6'b101010) e.res = (sa < sbv) ? 1 : 0;
        else if (op == 2'b10 && f == 6'b000010) begin
            s = sa * sbv;
            e.res = s[31:0];
        end else if (op == 2'b10 && f == 6'b011001) begin
            p = {32'h0, a} * {32'h0, b};
            e.res = p[31:0];
            e.hi  = p[63:32];
        end else if (op == 2'b10 && f == 6'b011011) begin
            if (b == 0) begin
                e.res = '1;
                e.hi  = a;
                e.dbz = 1'b1;
            end else begin
                e.res = a / b;
                e.hi  = a % b;
            end
        end else e.ill = 1'b1;
        e.zero = e.res == 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_g = {result, hi, zero, ovf, dbz, ill_op};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result %h hi %h with nothing expected", result, hi);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e) begin
                    errors++;
                    $display("FAIL result_compare: got res=%h hi=%h z=%b ovf=%b dbz=%b ill=%b expected res=%h hi=%h z=%b ovf=%b dbz=%b ill=%b",
                             mon_g.res, mon_g.hi, mon_g.zero, mon_g.ovf, mon_g.dbz, mon_g.ill,
                             mon_e.res, mon_e.hi, mon_e.zero, mon_e.ovf, mon_e.dbz, mon_e.ill);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        aluop = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(op, f, a, b));
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_lat(input string name, input int want, input bit ready_low);
        int n = 0, bad = 0;
        for (int i = 1; i <= want + 20 && n == 0; i++) begin
            @(negedge clk);
            if (out_valid) n = i;
            else if (in_ready) bad++;
        end
        chk({name, "_latency"}, n, want);
        if (ready_low) chk({name, "_in_ready_low"}, bad, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nvo;
        logic [1:0] op;
        logic [5:0] f;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {out_valid, result, hi, zero, ovf, dbz, ill_op}, 0);
        chk("reset_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b00, 6'h0, 32'h7fff_ffff, 32'h1);
        wait_lat("add_ovf", 1, 1'b0);
        @(posedge clk); #1;

        issue(2'b10, 6'b011001, '1, '1);
        wait_lat("multu", 33, 1'b1);
        @(posedge clk); #1;

        issue(2'b10, 6'b011011, 32'd100, 32'd7);
        wait_lat("divu", 33, 1'b1);
        @(posedge clk); #1;
        issue(2'b10, 6'b011011, 32'd5, 32'd0);
        wait_lat("divu_by0", 1, 1'b0);
        @(posedge clk); #1;

        rdy_force = 1'b0;
        @(posedge clk); #1;
        issue(2'b10, 6'b000010, 32'hffff_fffd, 32'd5);
        wait_lat("mul_neg", 33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("mul_hold_result", result, 32'hffff_fff1);
            chk("mul_hold_valid_ready", {out_valid, in_ready}, 2'b10);
            @(negedge clk);
        end
        rdy_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        issue(2'b10, 6'b011011, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        void'(exp_q.pop_back());
        nvo = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) nvo++;
        end
        chk("flush_no_output", nvo, 0);
        @(posedge clk); #1;
        issue(2'b10, 6'b101010, '1, 32'd2);
        wait_lat("slt", 1, 1'b0);
        @(posedge clk); #1;

        issue(2'b10, 6'b011001, 32'h1234_5678, 32'h9abc_def0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {out_valid, result, hi, zero, ovf, dbz, ill_op}, 0);
        chk("midreset_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'b11, 6'($urandom), W'($urandom), W'($urandom));
        wait_lat("illegal", 1, 1'b0);
        @(posedge clk); #1;

        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            case ($urandom_range(0, 9))
                0: op = 2'b00;
                1: op = 2'b01;
                2: op = 2'b11;
                default: op = 2'b10;
            endcase
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 7)];
            issue(op, f, pick(), pick());
        end
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        rdy_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
